id_ex_stage: RTL and testbench
==============================

# id_ex_stage

ID/EX pipeline register for the five-stage pipelined CPU. Sits directly downstream of the instruction-decode control logic. It captures the decoded EX/MEM/WB control bundle, operands and register specifiers each cycle. It detects load-use hazards against the instruction currently in EX and inserts a bubble while telling fetch/decode to hold. It also keeps a saturating bubble counter for performance debug.

## Interface
Parameters:
- DW, 64, datapath width of operands/immediate
- CW, 16, bubble counter width

Ports:
- clk  in  1  pipeline clock, all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- stall_in  in  1  global hold (memory not ready); freezes this stage
- id_ALUSrc, id_RegWrite, id_MemWrite, id_flagSet, id_read_en, id_reg3loc  in  1 each  decoded control from ID
- id_MemToReg  in  2  writeback mux select from ID
- id_ALUOP  in  3  ALU op from ID
- id_a, id_b, id_imm  in  DW  register-file operands and extended immediate
- id_rn, id_rm, id_rd  in  5  source A, source B and destination register numbers
- id_uses_rm  in  1  ID instruction reads id_rm (R-type, STUR, CBZ)
- ex_* outputs  out  same widths  registered copies of every id_* input above (ex_ALUSrc … ex_rd)
- ex_valid  out  1  EX holds a real instruction (0 = bubble)
- hazard_stall  out  1  combinational; ID/IF must hold this cycle
- bubble_count  out  CW  number of bubbles inserted since reset, saturating

## Operation
- Load-use detection (combinational): hazard_stall = ex_valid & ex_read_en & (ex_rd != 31) & ((ex_rd == id_rn) | (id_uses_rm & (ex_rd == id_rm))). Register 31 (XZR) never triggers.
- Per-edge update priority: reset_n low, then stall_in, then hazard_stall, then normal.
  - reset_n low: all ex_* = 0, ex_valid = 0, bubble_count = 0.
  - stall_in = 1: every register holds, including bubble_count. hazard_stall still reflects current EX contents.
  - hazard_stall = 1 (stall_in = 0): load bubble. All control outputs (ex_ALUSrc, ex_RegWrite, ex_MemWrite, ex_flagSet, ex_read_en, ex_reg3loc, ex_MemToReg, ex_ALUOP) = 0. ex_a/ex_b/ex_imm = 0, ex_rn/ex_rm/ex_rd = 31, ex_valid = 0. bubble_count increments unless all ones.
  - normal: all ex_* load the id_* values, ex_valid = 1.
- A bubble never writes registers, memory or flags. Downstream needs no extra gating beyond the zeroed controls.
- Load-use stalls last exactly one cycle. After the bubble, EX holds a non-load, and forwarding resolves the dependency from MEM.
- All-zero decoder output (NOP/zero instruction) loads normally with ex_valid = 1. It is not counted as a bubble.
- The `x` don't-care bits from the decoder are captured as-is. The bench compares only bits meaningful for the loaded opcode.

## Timing
- Latency: ID inputs are visible on ex_* one clk edge after capture.
- hazard_stall is combinational from ex_* and id_rn/id_rm/id_uses_rm, valid in the same cycle. It contains no path from stall_in.
- Reset is asynchronous: outputs go to reset values immediately on reset_n falling, independent of clk. Release is synchronous to the next rising edge.
- Reset mid-stall or mid-bubble: state is lost and ex_valid = 0. The first edge after release performs a normal load.
- bubble_count saturates at 2^CW − 1 and stays there until reset.
- Simultaneous stall_in and hazard: hold wins. The bubble is inserted on the first edge with stall_in = 0 if the hazard still exists.

## Test plan
- Reset: drive reset_n low asynchronously mid-cycle with random ex_* contents. Required: all ex_* = 0, ex_valid = 0, bubble_count = 0 before the next edge.
- Normal load: ADDS X3,X1,X2 decoded (ALUOP = 3'b010, RegWrite = 1, flagSet = 1, id_rd = 3). Required: next edge gives matching ex_* values, ex_valid = 1, hazard_stall = 0.
- Load-use: LDUR X5 in EX (ex_read_en = 1, ex_rd = 5) and SUBS using id_rm = 5, id_uses_rm = 1.
  - Required: hazard_stall = 1 that cycle, then a bubble (ex_valid = 0, ex_RegWrite = 0, ex_MemWrite = 0), and bubble_count increments by 1.
  - Next cycle: hazard_stall = 0 and SUBS loads.
- XZR / no-use cases: LDUR with ex_rd = 31 and id_rn = 31 gives hazard_stall = 0. id_rm matching with id_uses_rm = 0 gives hazard_stall = 0.
- stall_in overlap: assert stall_in for 3 cycles during a load-use hazard.
  - Required: ex_* and bubble_count frozen, hazard_stall held at 1.
  - The bubble is inserted on the first edge after stall_in drops.
- Saturation: with CW = 4, force 17 load-use hazards. Required: bubble_count stops at 15.

Source files
------------

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register: captures decoded control, operands and register numbers,
// inserts a bubble on a load-use hazard and counts the bubbles it has inserted.
module id_ex_stage #(
    parameter int DW = 64,
    parameter int CW = 16
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          stall_in,
    input  logic          id_ALUSrc,
    input  logic          id_RegWrite,
    input  logic          id_MemWrite,
    input  logic          id_flagSet,
    input  logic          id_read_en,
    input  logic          id_reg3loc,
    input  logic [1:0]    id_MemToReg,
    input  logic [2:0]    id_ALUOP,
    input  logic [DW-1:0] id_a,
    input  logic [DW-1:0] id_b,
    input  logic [DW-1:0] id_imm,
    input  logic [4:0]    id_rn,
    input  logic [4:0]    id_rm,
    input  logic [4:0]    id_rd,
    input  logic          id_uses_rm,
    output logic          ex_ALUSrc,
    output logic          ex_RegWrite,
    output logic          ex_MemWrite,
    output logic          ex_flagSet,
    output logic          ex_read_en,
    output logic          ex_reg3loc,
    output logic [1:0]    ex_MemToReg,
    output logic [2:0]    ex_ALUOP,
    output logic [DW-1:0] ex_a,
    output logic [DW-1:0] ex_b,
    output logic [DW-1:0] ex_imm,
    output logic [4:0]    ex_rn,
    output logic [4:0]    ex_rm,
    output logic [4:0]    ex_rd,
    output logic          ex_valid,
    output logic          hazard_stall,
    output logic [CW-1:0] bubble_count
);

    localparam logic [4:0] XZR = 5'd31;

    // A valid load in EX whose destination the ID instruction reads; XZR never conflicts.
    always_comb begin
        hazard_stall = ex_valid & ex_read_en & (ex_rd != XZR) &
                       ((ex_rd == id_rn) | (id_uses_rm & (ex_rd == id_rm)));
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples
    // pre-edge values; a blocking '=' here would make hazard_stall see the new EX contents.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            ex_ALUSrc    <= 1'b0;
            ex_RegWrite  <= 1'b0;
            ex_MemWrite  <= 1'b0;
            ex_flagSet   <= 1'b0;
            ex_read_en   <= 1'b0;
            ex_reg3loc   <= 1'b0;
            ex_MemToReg  <= 2'b0;
            ex_ALUOP     <= 3'b0;
            ex_a         <= '0;
            ex_b         <= '0;
            ex_imm       <= '0;
            ex_rn        <= 5'd0;
            ex_rm        <= 5'd0;
            ex_rd        <= 5'd0;
            ex_valid     <= 1'b0;
            bubble_count <= '0;
        end else if (stall_in) begin
            // Global hold: nothing changes, including the bubble counter.
        end else if (hazard_stall) begin
            ex_ALUSrc    <= 1'b0;
            ex_RegWrite  <= 1'b0;
            ex_MemWrite  <= 1'b0;
            ex_flagSet   <= 1'b0;
            ex_read_en   <= 1'b0;
            ex_reg3loc   <= 1'b0;
            ex_MemToReg  <= 2'b0;
            ex_ALUOP     <= 3'b0;
            ex_a         <= '0;
            ex_b         <= '0;
            ex_imm       <= '0;
            ex_rn        <= XZR;
            ex_rm        <= XZR;
            ex_rd        <= XZR;
            ex_valid     <= 1'b0;
            if (bubble_count != '1)
                bubble_count <= bubble_count + 1'b1;
        end else begin
            ex_ALUSrc    <= id_ALUSrc;
            ex_RegWrite  <= id_RegWrite;
            ex_MemWrite  <= id_MemWrite;
            ex_flagSet   <= id_flagSet;
            ex_read_en   <= id_read_en;
            ex_reg3loc   <= id_reg3loc;
            ex_MemToReg  <= id_MemToReg;
            ex_ALUOP     <= id_ALUOP;
            ex_a         <= id_a;
            ex_b         <= id_b;
            ex_imm       <= id_imm;
            ex_rn        <= id_rn;
            ex_rm        <= id_rm;
            ex_rd        <= id_rd;
            ex_valid     <= 1'b1;
        end
    end

endmodule

// File: tb/tb_id_ex_stage.sv
// Self-checking bench for id_ex_stage: directed hazard/stall/reset cases plus random
// traffic, all compared against a pipeline-level reference model.
module tb_id_ex_stage;

    localparam int DW = 64;
    localparam int CW = 4;
    localparam int SAT = (1 << CW) - 1;

    typedef struct packed {
        logic          alusrc;
        logic          regwrite;
        logic          memwrite;
        logic          flagset;
        logic          read_en;
        logic          reg3loc;
        logic [1:0]    memtoreg;
        logic [2:0]    aluop;
        logic [DW-1:0] a;
        logic [DW-1:0] b;
        logic [DW-1:0] imm;
        logic [4:0]    rn;
        logic [4:0]    rm;
        logic [4:0]    rd;
        logic          uses_rm;
    } instr_t;

    logic clk = 1'b0;
    logic reset_n;
    logic stall_in;
    instr_t cur;

    logic          ex_ALUSrc, ex_RegWrite, ex_MemWrite, ex_flagSet, ex_read_en, ex_reg3loc;
    logic [1:0]    ex_MemToReg;
    logic [2:0]    ex_ALUOP;
    logic [DW-1:0] ex_a, ex_b, ex_imm;
    logic [4:0]    ex_rn, ex_rm, ex_rd;
    logic          ex_valid, hazard_stall;
    logic [CW-1:0] bubble_count;

    // Reference model state: what EX should hold, plus the bubble tally.
    instr_t m_ex;
    bit     m_valid;
    int     m_count;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    id_ex_stage #(.DW(DW), .CW(CW)) dut (
        .clk(clk), .reset_n(reset_n), .stall_in(stall_in),
        .id_ALUSrc(cur.alusrc), .id_RegWrite(cur.regwrite), .id_MemWrite(cur.memwrite),
        .id_flagSet(cur.flagset), .id_read_en(cur.read_en), .id_reg3loc(cur.reg3loc),
        .id_MemToReg(cur.memtoreg), .id_ALUOP(cur.aluop),
        .id_a(cur.a), .id_b(cur.b), .id_imm(cur.imm),
        .id_rn(cur.rn), .id_rm(cur.rm), .id_rd(cur.rd), .id_uses_rm(cur.uses_rm),
        .ex_ALUSrc(ex_ALUSrc), .ex_RegWrite(ex_RegWrite), .ex_MemWrite(ex_MemWrite),
        .ex_flagSet(ex_flagSet), .ex_read_en(ex_read_en), .ex_reg3loc(ex_reg3loc),
        .ex_MemToReg(ex_MemToReg), .ex_ALUOP(ex_ALUOP),
        .ex_a(ex_a), .ex_b(ex_b), .ex_imm(ex_imm),
        .ex_rn(ex_rn), .ex_rm(ex_rm), .ex_rd(ex_rd),
        .ex_valid(ex_valid), .hazard_stall(hazard_stall), .bubble_count(bubble_count)
    );

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // The ID instruction must wait if EX holds a real load into a register it reads.
    function automatic bit model_hazard();
        bit reads_dest;
        reads_dest = (cur.rn == m_ex.rd) || (cur.uses_rm && cur.rm == m_ex.rd);
        return m_valid && m_ex.read_en && (m_ex.rd != 5'd31) && reads_dest;
    endfunction

    task automatic model_reset();
        m_ex    = '0;
        m_valid = 0;
        m_count = 0;
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".ctrl"}, {ex_ALUSrc, ex_RegWrite, ex_MemWrite, ex_flagSet, ex_read_en,
                               ex_reg3loc, ex_MemToReg, ex_ALUOP},
              {m_ex.alusrc, m_ex.regwrite, m_ex.memwrite, m_ex.flagset, m_ex.read_en,
               m_ex.reg3loc, m_ex.memtoreg, m_ex.aluop});
        check({tag, ".a"}, ex_a, m_ex.a);
        check({tag, ".b"}, ex_b, m_ex.b);
        check({tag, ".imm"}, ex_imm, m_ex.imm);
        check({tag, ".regs"}, {ex_rn, ex_rm, ex_rd}, {m_ex.rn, m_ex.rm, m_ex.rd});
        check({tag, ".valid"}, ex_valid, m_valid);
        check({tag, ".count"}, bubble_count, m_count);
    endtask

    // One clock: check hazard mid-cycle, advance the model at the edge, check EX after.
    task automatic step(input string tag);
        bit hz;
        @(negedge clk);
        hz = model_hazard();
        check({tag, ".hazard"}, hazard_stall, hz);
        @(posedge clk);
        if (!stall_in) begin
            if (hz) begin
                m_ex    = '0;
                m_ex.rn = 5'd31;
                m_ex.rm = 5'd31;
                m_ex.rd = 5'd31;
                m_valid = 0;
                if (m_count < SAT) m_count++;
            end else begin
                m_ex    = cur;
                m_valid = 1;
            end
        end
        #1;
        check_outputs(tag);
    endtask

    function automatic logic [4:0] rand_reg();
        return ($urandom_range(0, 5) == 0) ? 5'd31 : 5'($urandom_range(0, 6));
    endfunction

    function automatic instr_t rand_instr();
        instr_t i;
        i          = '0;
        i.alusrc   = 1'($urandom);
        i.regwrite = 1'($urandom);
        i.memwrite = 1'($urandom);
        i.flagset  = 1'($urandom);
        i.read_en  = 1'($urandom);
        i.reg3loc  = 1'($urandom);
        i.memtoreg = 2'($urandom);
        i.aluop    = 3'($urandom);
        i.a        = {$urandom, $urandom};
        i.b        = {$urandom, $urandom};
        i.imm      = {$urandom, $urandom};
        i.rn       = rand_reg();
        i.rm       = rand_reg();
        i.rd       = rand_reg();
        i.uses_rm  = 1'($urandom);
        return i;
    endfunction

    function automatic instr_t ldur(input logic [4:0] rd, input logic [4:0] rn);
        instr_t i;
        i          = '0;
        i.alusrc   = 1'b1;
        i.regwrite = 1'b1;
        i.read_en  = 1'b1;
        i.memtoreg = 2'b01;
        i.rn       = rn;
        i.rd       = rd;
        i.imm      = 64'h10;
        i.a        = 64'h1000;
        return i;
    endfunction

    function automatic instr_t rtype(input logic [2:0] op, input logic [4:0] rd,
                                     input logic [4:0] rn, input logic [4:0] rm,
                                     input logic use_rm);
        instr_t i;
        i          = '0;
        i.regwrite = 1'b1;
        i.flagset  = 1'b1;
        i.aluop    = op;
        i.rd       = rd;
        i.rn       = rn;
        i.rm       = rm;
        i.uses_rm  = use_rm;
        i.a        = 64'h0123_4567_89ab_cdef;
        i.b        = 64'hfedc_ba98_7654_3210;
        return i;
    endfunction

    initial begin
        reset_n  = 1'b0;
        stall_in = 1'b0;
        cur      = '0;
        model_reset();
        #1;
        check_outputs("reset");
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // ADDS X3,X1,X2
        cur = rtype(3'b010, 5'd3, 5'd1, 5'd2, 1'b1);
        step("adds");
        check("adds.valid1", ex_valid, 1'b1);

        // LDUR X5 then SUBS X7,X6,X5: one bubble, then SUBS loads
        cur = ldur(5'd5, 5'd1);
        step("ldur5");
        cur = rtype(3'b011, 5'd7, 5'd6, 5'd5, 1'b1);
        step("lu.bubble");
        check("lu.bubble_ctrl", {ex_valid, ex_RegWrite, ex_MemWrite}, 3'b000);
        check("lu.count1", bubble_count, 4'd1);
        step("lu.subs");
        check("lu.subs_rd", ex_rd, 5'd7);

        // XZR destination never conflicts; rm match ignored when rm is unused
        cur = ldur(5'd31, 5'd2);
        step("xzr.load");
        cur = ldur(5'd4, 5'd31);
        step("xzr.use");
        cur = rtype(3'b010, 5'd8, 5'd9, 5'd4, 1'b0);
        step("norm.use");
        check("norm.loaded", ex_rd, 5'd8);

        // stall_in held 3 cycles over a load-use hazard; bubble on first free edge
        cur = ldur(5'd5, 5'd2);
        step("ov.load");
        cur = rtype(3'b011, 5'd6, 5'd5, 5'd1, 1'b1);
        stall_in = 1'b1;
        for (int k = 0; k < 3; k++) step("ov.hold");
        check("ov.still_load", {ex_valid, ex_read_en, ex_rd}, {2'b11, 5'd5});
        stall_in = 1'b0;
        step("ov.bubble");
        step("ov.subs");

        // Saturation: 17 load-use bubbles on a 4-bit counter
        for (int k = 0; k < 17; k++) begin
            cur = ldur(5'd2, 5'd1);
            step("sat.load");
            cur = rtype(3'b010, 5'd3, 5'd2, 5'd0, 1'b0);
            step("sat.bubble");
            step("sat.use");
        end
        check("sat.final", bubble_count, 4'hf);

        // Random traffic with occasional global holds
        for (int k = 0; k < 400; k++) begin
            cur      = rand_instr();
            stall_in = ($urandom_range(0, 4) == 0);
            step("rand");
        end
        stall_in = 1'b0;

        // Asynchronous reset mid-cycle, released with a normal load pending
        cur = ldur(5'd5, 5'd1);
        step("ar.load");
        cur = rtype(3'b011, 5'd6, 5'd5, 5'd5, 1'b1);
        #2;
        reset_n = 1'b0;
        model_reset();
        #1;
        check_outputs("async_reset");
        check("async_reset.hazard", hazard_stall, 1'b0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        step("ar.first_load");
        check("ar.first_valid", ex_valid, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1);
    end

endmodule
